// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU results
// queue in a small FIFO and drain on idle cycles; a pending scoreboard stalls hazards.
module rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_addr,
  input  logic [31:0]              pipe_wd,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_addr,
  input  logic [31:0]              mdu_wd,
  input  logic                     issue_valid,
  input  logic                     issue_mdu,
  input  logic [4:0]               issue_dst,
  input  logic [4:0]               chk_addr1,
  input  logic [4:0]               chk_addr2,
  output logic                     stall,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [31:0]              rf_wd,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     waw_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;

  logic pipe_act;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic sb_set;
  logic [4:0]  head_addr;
  logic [31:0] head_wd;

  assign pipe_act  = pipe_we && (pipe_addr != 5'd0);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign mdu_ready = !full;
  // r0 results are accepted (handshake completes) but never stored
  assign push      = mdu_valid && !full && (mdu_addr != 5'd0);
  assign pop       = !pipe_act && !empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_wd   = data_mem[rd_ptr];

  assign stall  = issue_valid &&
                  (pending[chk_addr1] || pending[chk_addr2] || pending[issue_dst]);
  assign sb_set = issue_valid && issue_mdu && !stall && (issue_dst != 5'd0);

  assign fifo_count = count;

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_wd   = 32'd0;
    if (pipe_act) begin
      rf_we   = 1'b1;
      rf_addr = pipe_addr;
      rf_wd   = pipe_wd;
    end else if (!empty) begin
      rf_we   = 1'b1;
      rf_addr = head_addr;
      rf_wd   = head_wd;
    end
  end

  // Clear before set so a re-issue to the register being drained stays pending
  always_comb begin
    pending_nxt = pending;
    if (pop)
      pending_nxt[head_addr] = 1'b0;
    if (sb_set)
      pending_nxt[issue_dst] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= mdu_addr;
      data_mem[wr_ptr] <= mdu_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      waw_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      pending <= pending_nxt;
      if (pipe_act && pending[pipe_addr])
        waw_err <= 1'b1;
    end
  end

endmodule
